// File: rtl/bc_control_unit.sv
// bc_control_unit: basic-computer timing/control sequencer driving bus select and register strobes
module bc_control_unit #(
  parameter int WIDTH  = 16,
  parameter int SC_W   = 4,
  parameter int INT_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ir,
  input  logic             dr_zero,
  input  logic             ac_msb,
  input  logic             ac_zero,
  input  logic             e_flag,
  input  logic             fgi,
  input  logic             fgo,
  input  logic             start,
  output logic [2:0]       bus_sel,
  output logic [25:0]      ctrl,
  output logic [SC_W-1:0]  t_state,
  output logic             halted,
  output logic             ien,
  output logic             int_cycle
);
  localparam int AR_LD = 0, AR_INR = 1, AR_CLR = 2, PC_LD = 3, PC_INR = 4, PC_CLR = 5;
  localparam int DR_LD = 6, DR_INR = 7, AC_LD = 8, AC_INR = 9, AC_CLR = 10, IR_LD = 11;
  localparam int TR_LD = 12, MEM_WR = 13, ALU_AND = 14, ALU_ADD = 15, ALU_DR = 16, ALU_CMA = 17;
  localparam int ALU_SHR = 18, ALU_SHL = 19, ALU_INP = 20, E_CLR = 21, E_CMP = 22;
  localparam int OUTR_LD = 23, FGI_CLR = 24, FGO_CLR = 25;
  logic [SC_W-1:0] sc;
  logic            i_ff, r_ff, ien_ff, s_ff;
  logic            sc_clr, ien_set, ien_clr, r_clr, hlt, i_ld, int_req;
  logic [7:0]      d;
  assign d         = 8'(1) << ir[WIDTH-2:WIDTH-4];
  assign int_req   = (INT_EN != 0) && (sc > SC_W'(2)) && ien_ff && (fgi | fgo);
  assign t_state   = sc;
  assign halted    = ~s_ff;
  assign ien       = ien_ff;
  assign int_cycle = r_ff;
  // decode the current timing step into bus source, strobes and state-update requests
  always_comb begin
    bus_sel = 3'd0;
    ctrl    = '0;
    sc_clr  = 1'b0;
    ien_set = 1'b0;
    ien_clr = 1'b0;
    r_clr   = 1'b0;
    hlt     = 1'b0;
    i_ld    = 1'b0;
    if (s_ff) begin
      if (r_ff && sc == SC_W'(0)) begin
        bus_sel = 3'd2; ctrl[AR_CLR] = 1'b1; ctrl[TR_LD] = 1'b1;
      end else if (r_ff && sc == SC_W'(1)) begin
        bus_sel = 3'd6; ctrl[MEM_WR] = 1'b1; ctrl[PC_CLR] = 1'b1;
      end else if (r_ff && sc == SC_W'(2)) begin
        ctrl[PC_INR] = 1'b1; ien_clr = 1'b1; r_clr = 1'b1; sc_clr = 1'b1;
      end else if (sc == SC_W'(0)) begin
        bus_sel = 3'd2; ctrl[AR_LD] = 1'b1;
      end else if (sc == SC_W'(1)) begin
        bus_sel = 3'd7; ctrl[IR_LD] = 1'b1; ctrl[PC_INR] = 1'b1;
      end else if (sc == SC_W'(2)) begin
        bus_sel = 3'd5; ctrl[AR_LD] = 1'b1; i_ld = 1'b1;
      end else if (sc == SC_W'(3)) begin
        if (!d[7]) begin
          bus_sel      = i_ff ? 3'd7 : 3'd0;
          ctrl[AR_LD]  = i_ff;
        end else if (!i_ff) begin
          ctrl[AC_CLR]  = ir[11];
          ctrl[E_CLR]   = ir[10];
          ctrl[AC_LD]   = ir[9] | ir[7] | ir[6];
          ctrl[ALU_CMA] = ir[9];
          ctrl[E_CMP]   = ir[8];
          ctrl[ALU_SHR] = ir[7];
          ctrl[ALU_SHL] = ir[6];
          ctrl[AC_INR]  = ir[5];
          ctrl[PC_INR]  = (ir[4] & ~ac_msb) | (ir[3] & ac_msb) | (ir[2] & ac_zero) | (ir[1] & ~e_flag);
          hlt           = ir[0];
          sc_clr        = 1'b1;
        end else begin
          bus_sel       = ir[10] ? 3'd4 : 3'd0;
          ctrl[AC_LD]   = ir[11];
          ctrl[ALU_INP] = ir[11];
          ctrl[FGI_CLR] = ir[11];
          ctrl[OUTR_LD] = ir[10];
          ctrl[FGO_CLR] = ir[10];
          ctrl[PC_INR]  = (ir[9] & fgi) | (ir[8] & fgo);
          ien_set       = ir[7];
          ien_clr       = ir[6];
          sc_clr        = 1'b1;
        end
      end else if (sc == SC_W'(4)) begin
        if (d[0] | d[1] | d[2] | d[6]) begin
          bus_sel = 3'd7; ctrl[DR_LD] = 1'b1;
        end else if (d[3]) begin
          bus_sel = 3'd4; ctrl[MEM_WR] = 1'b1; sc_clr = 1'b1;
        end else if (d[4]) begin
          bus_sel = 3'd1; ctrl[PC_LD] = 1'b1; sc_clr = 1'b1;
        end else if (d[5]) begin
          bus_sel = 3'd2; ctrl[MEM_WR] = 1'b1; ctrl[AR_INR] = 1'b1;
        end
      end else if (sc == SC_W'(5)) begin
        if (d[0] | d[1] | d[2]) begin
          ctrl[AC_LD]   = 1'b1;
          ctrl[ALU_AND] = d[0];
          ctrl[ALU_ADD] = d[1];
          ctrl[ALU_DR]  = d[2];
          sc_clr        = 1'b1;
        end else if (d[5]) begin
          bus_sel = 3'd1; ctrl[PC_LD] = 1'b1; sc_clr = 1'b1;
        end else if (d[6]) begin
          ctrl[DR_INR] = 1'b1;
        end
      end else if (sc == SC_W'(6) && d[6]) begin
        bus_sel = 3'd3; ctrl[MEM_WR] = 1'b1; ctrl[PC_INR] = dr_zero; sc_clr = 1'b1;
      end
    end
  end
  // sequence counter and the I, R, IEN, S flip-flops; halted state only waits for start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc     <= '0;
      i_ff   <= 1'b0;
      r_ff   <= 1'b0;
      ien_ff <= 1'b0;
      s_ff   <= 1'b1;
    end else if (!s_ff) begin
      if (start) begin
        s_ff <= 1'b1;
        sc   <= '0;
      end
    end else begin
      sc <= sc_clr ? '0 : sc + SC_W'(1);
      if (i_ld) i_ff <= ir[WIDTH-1];
      if (hlt) s_ff <= 1'b0;
      if (ien_clr) ien_ff <= 1'b0;
      else if (ien_set) ien_ff <= 1'b1;
      if (r_clr) r_ff <= 1'b0;
      else if (int_req) r_ff <= 1'b1;
    end
  end
endmodule

// File: doc/bc_control_unit.md
BC_CONTROL_UNIT -- requirements
Module: bc_control_unit

Interface
REQ-001 Parameter WIDTH, default 16, data/IR width (SHALL be >= 16); address width AW = WIDTH-4.
REQ-002 Parameter SC_W, default 4, sequence-counter width; timing states T0..T(2^SC_W-1).
REQ-003 Parameter INT_EN, default 1; when 0, interrupt logic is removed and R is held at 0.
REQ-004 clk  in  1  single clock; all state updates occur on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ir  in  WIDTH  instruction register contents; I=ir[WIDTH-1], opcode=ir[WIDTH-2:WIDTH-4], reg/IO select=ir[11:0].
REQ-007 dr_zero, ac_msb, ac_zero, e_flag, fgi, fgo  in  1 each  datapath status: DR==0, AC sign, AC==0, E, input flag, output flag.
REQ-008 start  in  1  one-cycle pulse that resumes execution after HLT.
REQ-009 bus_sel  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory.
REQ-010 ctrl  out  26  one-hot control strobes. Bit map: 0 AR_LD, 1 AR_INR, 2 AR_CLR, 3 PC_LD, 4 PC_INR, 5 PC_CLR, 6 DR_LD, 7 DR_INR, 8 AC_LD, 9 AC_INR, 10 AC_CLR, 11 IR_LD, 12 TR_LD, 13 MEM_WR, 14 ALU_AND, 15 ALU_ADD, 16 ALU_DR, 17 ALU_CMA, 18 ALU_SHR, 19 ALU_SHL, 20 ALU_INP, 21 E_CLR, 22 E_CMP, 23 OUTR_LD, 24 FGI_CLR, 25 FGO_CLR.
REQ-011 t_state  out  SC_W  current sequence-counter value.
REQ-012 halted, ien, int_cycle  out  1 each  S flip-flop inverted, interrupt-enable flip-flop, R flip-flop.

Function
REQ-013 bus_sel and ctrl SHALL be combinational functions of SC, decoded D0..D7, I, R, S, ir and the status inputs; all are 0 in any state not listed below.
REQ-014 Registered state: SC, I, R, IEN, S; SC increments every cycle unless cleared; SC wraps 2^SC_W-1 -> 0.
REQ-015 When S=0, SC holds, ctrl=0 and bus_sel=0; start=1 sets S and clears SC the same edge.
REQ-016 Fetch (R=0): T0 bus=PC, AR_LD; T1 bus=mem, IR_LD, PC_INR; T2 bus=IR, AR_LD, I<=ir[WIDTH-1].
REQ-017 T3, D7=0: I=1 -> bus=mem, AR_LD (indirect); I=0 -> no strobes; proceed to T4.
REQ-018 Execute, each final step also clears SC: AND/ADD/LDA (D0/D1/D2) T4 bus=mem, DR_LD; T5 AC_LD with ALU_AND/ALU_ADD/ALU_DR. STA D3 T4 bus=AC, MEM_WR. BUN D4 T4 bus=AR, PC_LD. BSA D5 T4 bus=PC, MEM_WR, AR_INR; T5 bus=AR, PC_LD. ISZ D6 T4 bus=mem, DR_LD; T5 DR_INR; T6 bus=DR, MEM_WR, PC_INR iff dr_zero.
REQ-019 Register-reference (D7, I=0, T3), per set ir bit, then SC cleared: 11 AC_CLR; 10 E_CLR; 9 AC_LD+ALU_CMA; 8 E_CMP; 7 AC_LD+ALU_SHR; 6 AC_LD+ALU_SHL; 5 AC_INR; 4 PC_INR iff !ac_msb; 3 PC_INR iff ac_msb; 2 PC_INR iff ac_zero; 1 PC_INR iff !e_flag; 0 S<=0.
REQ-020 I/O (D7, I=1, T3), then SC cleared: 11 AC_LD+ALU_INP+FGI_CLR; 10 bus=AC, OUTR_LD, FGO_CLR; 9 PC_INR iff fgi; 8 PC_INR iff fgo; 7 IEN<=1; 6 IEN<=0.
REQ-021 Multiple ir[11:0] bits set SHALL OR their strobes; zero bits set is a NOP that still clears SC.
REQ-022 R<=1 on an edge where SC not in {T0,T1,T2}, IEN=1, (fgi|fgo)=1 and INT_EN=1; an SC clear on that same edge still occurs.
REQ-023 Interrupt cycle (R=1) replaces fetch: T0 AR_CLR, bus=PC, TR_LD; T1 bus=TR, MEM_WR, PC_CLR; T2 PC_INR, IEN<=0, R<=0, SC<=0.
REQ-024 HLT and clear-SC on the same edge: S<=0 and SC<=0 both take effect.

Reset
REQ-025 rst_n=0 SHALL immediately set SC=0, I=0, R=0, IEN=0, S=1; outputs then show T0 fetch strobes (bus_sel=2, ctrl[0]=1), halted=0.
REQ-026 Reset asserted mid-instruction SHALL abandon it; first rising edge after release advances to T1.

Verification
REQ-027 Reset release, ir=0x2005 (LDA direct) -> T0 bus 2/AR_LD, T1 bus 7/IR_LD+PC_INR, T2 bus 5, T4 bus 7/DR_LD, T5 AC_LD+ALU_DR, then t_state=0.
REQ-028 ir=0xE005 (ISZ indirect), dr_zero=1 at T6 -> T3 bus 7/AR_LD; T6 bus 3, MEM_WR, PC_INR; 7-cycle instruction.
REQ-029 ir=0x7001 (HLT) -> halted=1 after T3, ctrl=0 for 10 cycles; start pulse -> next cycle T0 with bus_sel=2.
REQ-030 ION (0xF080), then fgi=1 during next instruction's T4 -> int_cycle=1; following T0..T2 show AR_CLR+TR_LD, MEM_WR+PC_CLR, PC_INR; ien=0, int_cycle=0 after.
REQ-031 ir=0x7820 (CLA+INC) -> T3 ctrl[10] and ctrl[9] both 1; rst_n low at T5 of BSA -> t_state=0 asynchronously.
